// File: rtl/mem_port_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one sram-like master port between the instruction-fetch
//            port and the data-memory port. Only one transaction can be in
//            flight at a time. The grant is held from request until data
//            return. addr_ok, data_ok and rdata are returned only to the
//            requester that owns the transaction.
// Ports    : clk, rst (async, active-low)
//            inst_* : fetch request in / response out
//            data_* : data-memory request in / response out
//            m_*    : shared master request out / response in
//            busy   : a transaction is in progress (state != IDLE)
// Options  : ARB_ROUND_ROBIN_EN - when both requesters ask in IDLE, grant
//            the one that did not own the previous transaction. When the
//            macro is not defined, the data port has fixed priority.
// Revision : 1.0 - initial release
//==============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // instruction-fetch port
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    input  logic              inst_uncached,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    // data-memory port
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic              data_uncached,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    // shared master port
    output logic              m_req,
    output logic              m_wr,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_uncached,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    // status
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ADDR = 2'd1,
        ST_WAIT_DATA = 2'd2
    } state_t;

    localparam logic c_own_inst = 1'b0;
    localparam logic c_own_data = 1'b1;

    state_t            r_state;
    logic              r_owner;
`ifdef ARB_ROUND_ROBIN_EN
    logic              r_last_owner;
`endif

    // Copy of the request taken when the address is accepted. The bus keeps
    // presenting it while the data phase is pending, even after the requester
    // has moved on.
    logic              r_h_wr;
    logic [1:0]        r_h_size;
    logic [ADDR_W-1:0] r_h_addr;
    logic [DATA_W-1:0] r_h_wdata;
    logic              r_h_uncached;

    logic              w_idle;
    logic              w_sel_valid;
    logic              w_sel_data;
    logic              w_grant;
    logic              w_gr_req;
    logic              w_gr_wr;
    logic [1:0]        w_gr_size;
    logic [ADDR_W-1:0] w_gr_addr;
    logic [DATA_W-1:0] w_gr_wdata;
    logic              w_gr_uncached;

    logic              w_m_req;
    logic              w_m_wr;
    logic [1:0]        w_m_size;
    logic [ADDR_W-1:0] w_m_addr;
    logic [DATA_W-1:0] w_m_wdata;
    logic              w_m_uncached;

    logic              w_addr_acc;
    logic              w_data_hit;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_sel_valid = inst_req | data_req;

`ifdef ARB_ROUND_ROBIN_EN
    // Under contention, grant the requester that did not own the last transaction.
    assign w_sel_data  = (inst_req && data_req) ? (r_last_owner == c_own_inst) : data_req;
`else
    assign w_sel_data  = data_req;
`endif

    // The selection is only live in IDLE. After that, the owner is locked.
    assign w_grant       = w_idle ? w_sel_data : r_owner;
    assign w_gr_req      = w_grant ? data_req      : inst_req;
    assign w_gr_wr       = w_grant ? data_wr       : inst_wr;
    assign w_gr_size     = w_grant ? data_size     : inst_size;
    assign w_gr_addr     = w_grant ? data_addr     : inst_addr;
    assign w_gr_wdata    = w_grant ? data_wdata    : inst_wdata;
    assign w_gr_uncached = w_grant ? data_uncached : inst_uncached;

    always_comb begin
        w_m_req      = 1'b0;
        w_m_wr       = 1'b0;
        w_m_size     = '0;
        w_m_addr     = '0;
        w_m_wdata    = '0;
        w_m_uncached = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_valid) begin
                    w_m_req      = 1'b1;
                    w_m_wr       = w_gr_wr;
                    w_m_size     = w_gr_size;
                    w_m_addr     = w_gr_addr;
                    w_m_wdata    = w_gr_wdata;
                    w_m_uncached = w_gr_uncached;
                end
            end
            ST_WAIT_ADDR: begin
                w_m_req      = w_gr_req;
                w_m_wr       = w_gr_wr;
                w_m_size     = w_gr_size;
                w_m_addr     = w_gr_addr;
                w_m_wdata    = w_gr_wdata;
                w_m_uncached = w_gr_uncached;
            end
            ST_WAIT_DATA: begin
                w_m_wr       = r_h_wr;
                w_m_size     = r_h_size;
                w_m_addr     = r_h_addr;
                w_m_wdata    = r_h_wdata;
                w_m_uncached = r_h_uncached;
            end
            default: ;
        endcase
    end

    // An address handshake counts only when a request is driven. A data_ok
    // counts in the data phase, or together with an address accept. A stray
    // strobe in any other situation is dropped and not forwarded.
    assign w_addr_acc = w_m_req && m_addr_ok;
    assign w_data_hit = m_data_ok && ((r_state == ST_WAIT_DATA) || w_addr_acc);

    // During reset the state is already IDLE. The IDLE outputs are a
    // combinational function of the inputs, so they are masked with rst.
    assign m_req        = rst && w_m_req;
    assign m_wr         = rst && w_m_wr;
    assign m_size       = rst ? w_m_size : '0;
    assign m_addr       = rst ? w_m_addr : '0;
    assign m_wdata      = rst ? w_m_wdata : '0;
    assign m_uncached   = rst && w_m_uncached;

    assign inst_addr_ok = rst && w_addr_acc && (w_grant == c_own_inst);
    assign data_addr_ok = rst && w_addr_acc && (w_grant == c_own_data);
    assign inst_data_ok = rst && w_data_hit && (w_grant == c_own_inst);
    assign data_data_ok = rst && w_data_hit && (w_grant == c_own_data);
    assign inst_rdata   = inst_data_ok ? m_rdata : '0;
    assign data_rdata   = data_data_ok ? m_rdata : '0;

    assign busy         = !w_idle;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= c_own_inst;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_owner <= c_own_data;
`endif
            r_h_wr       <= 1'b0;
            r_h_size     <= '0;
            r_h_addr     <= '0;
            r_h_wdata    <= '0;
            r_h_uncached <= 1'b0;
        end else begin
            if (w_addr_acc) begin
                r_h_wr       <= w_m_wr;
                r_h_size     <= w_m_size;
                r_h_addr     <= w_m_addr;
                r_h_wdata    <= w_m_wdata;
                r_h_uncached <= w_m_uncached;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_valid) begin
                        r_owner      <= w_sel_data;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_owner <= w_sel_data;
`endif
                        if (m_addr_ok && m_data_ok) begin
                            r_state <= ST_IDLE;
                        end else if (m_addr_ok) begin
                            r_state <= ST_WAIT_DATA;
                        end else begin
                            r_state <= ST_WAIT_ADDR;
                        end
                    end
                end
                ST_WAIT_ADDR: begin
                    // The owner withdrew the request, so the transaction is abandoned.
                    if (!w_gr_req) begin
                        r_state <= ST_IDLE;
                    end else if (m_addr_ok && m_data_ok) begin
                        r_state <= ST_IDLE;
                    end else if (m_addr_ok) begin
                        r_state <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (m_data_ok) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed, table-driven testbench for mem_port_arbiter. Each table
//            row is one clock cycle. The row holds the inputs and the expected
//            outputs. Inputs change on the falling edge. Outputs are sampled
//            just before the next rising edge.
// Revision : 1.0 - initial release
//==============================================================================
module tb_mem_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // Expected bus owner codes used by the table.
    localparam int NONE = 0;
    localparam int INST = 1;
    localparam int DATA = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, inst_uncached;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req, data_wr, data_uncached;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic        m_req, m_wr, m_uncached;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_addr_ok, m_data_ok;
    logic        busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_uncached(inst_uncached),
        .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_uncached(data_uncached),
        .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_uncached(m_uncached),
        .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
        .busy(busy)
    );

    typedef struct {
        logic        rst, ir;
        logic [31:0] ia;
        logic        dr;
        logic [31:0] da;
        logic        aok, dok;
        logic [31:0] rd;
        int          own;
        logic        mreq, iaok, idok;
        logic [31:0] ird;
        logic        daok, ddok;
        logic [31:0] drd;
        logic        busy;
    } vec_t;

    vec_t vecs [0:63];
    int   nvec  = 0;
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic r, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic [31:0] da,
                       input logic aok, input logic dok, input logic [31:0] rd,
                       input int own, input logic mreq,
                       input logic iaok, input logic idok, input logic [31:0] ird,
                       input logic daok, input logic ddok, input logic [31:0] drd,
                       input logic bsy);
        vecs[nvec] = '{r, ir, ia, dr, da, aok, dok, rd, own, mreq,
                       iaok, idok, ird, daok, ddok, drd, bsy};
        nvec++;
    endtask

    task automatic chk(input int idx, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL row%0d %s: got %h want %h", idx, name, act, exp);
        end
    endtask

    initial begin
        int o;
        // Fixed per-port request attributes, so the bench can tell from the
        // bus fields which port is being forwarded.
        inst_wr = 1'b0; inst_size = 2'd2; inst_wdata = 32'h1111_1111; inst_uncached = 1'b1;
        data_wr = 1'b1; data_size = 2'd1; data_wdata = 32'h2222_2222; data_uncached = 1'b0;
        rst = 1'b0; inst_req = 1'b0; data_req = 1'b0; inst_addr = '0; data_addr = '0;
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;

        //   rst ir ia           dr da           aok dok rd            own  mreq iaok idok ird           daok ddok drd           busy
        // Reset with a pending fetch request: every output is 0.
        add(0, 1, 32'h1FC0_0000, 1, 32'h8000_0000, 1, 1, 32'h1234_5678, NONE, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        // Fetch: address is accepted one cycle later, data comes two cycles after that.
        add(1, 1, 32'h1FC0_0000, 0, 32'h0,        0, 0, 32'h0,         INST, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        add(1, 1, 32'h1FC0_0000, 0, 32'h0,        1, 0, 32'h0,         INST, 1, 1, 0, 32'h0, 0, 0, 32'h0, 1);
        add(1, 0, 32'h1FC0_0000, 0, 32'h0,        0, 0, 32'h3C08_0001, INST, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1);
        add(1, 0, 32'h1FC0_0000, 0, 32'h0,        0, 1, 32'h3C08_0001, INST, 0, 0, 1, 32'h3C08_0001, 0, 0, 32'h0, 1);
        add(1, 0, 32'h1FC0_0000, 0, 32'h0,        0, 0, 32'h0,         NONE, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        // Both ask: data wins. Inst is granted the cycle after the data return.
        add(1, 1, 32'h1FC0_0040, 1, 32'h8000_1000, 0, 0, 32'h0,         DATA, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        add(1, 1, 32'h1FC0_0040, 1, 32'h8000_1000, 1, 0, 32'h0,         DATA, 1, 0, 0, 32'h0, 1, 0, 32'h0, 1);
        add(1, 1, 32'h1FC0_0040, 0, 32'h8000_1000, 0, 1, 32'hAAAA_5555, DATA, 0, 0, 0, 32'h0, 0, 1, 32'hAAAA_5555, 1);
        add(1, 1, 32'h1FC0_0040, 0, 32'h8000_1000, 0, 0, 32'h0,         INST, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        add(1, 1, 32'h1FC0_0040, 0, 32'h8000_1000, 1, 1, 32'h1234_5678, INST, 1, 1, 1, 32'h1234_5678, 0, 0, 32'h0, 1);
        add(1, 0, 32'h1FC0_0040, 0, 32'h8000_1000, 0, 0, 32'h0,         NONE, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        // Grant lock: data asks while inst is in WAIT_ADDR. Also covers a stray
        // addr_ok in WAIT_DATA and an abort in WAIT_ADDR.
        add(1, 1, 32'h1FC0_0100, 0, 32'h8000_2000, 0, 0, 32'h0,         INST, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        add(1, 1, 32'h1FC0_0100, 1, 32'h8000_2000, 0, 0, 32'h0,         INST, 1, 0, 0, 32'h0, 0, 0, 32'h0, 1);
        add(1, 1, 32'h1FC0_0100, 1, 32'h8000_2000, 1, 0, 32'h0,         INST, 1, 1, 0, 32'h0, 0, 0, 32'h0, 1);
        add(1, 0, 32'h1FC0_0100, 1, 32'h8000_2000, 1, 0, 32'h0,         INST, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1);
        add(1, 0, 32'h1FC0_0100, 1, 32'h8000_2000, 0, 1, 32'h0BAD_F00D, INST, 0, 0, 1, 32'h0BAD_F00D, 0, 0, 32'h0, 1);
        add(1, 0, 32'h1FC0_0100, 1, 32'h8000_2000, 0, 0, 32'h0,         DATA, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        add(1, 0, 32'h1FC0_0100, 0, 32'h8000_2000, 1, 0, 32'h0,         DATA, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1);
        add(1, 0, 32'h1FC0_0100, 0, 32'h8000_2000, 0, 0, 32'h0,         NONE, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        // Reset during WAIT_DATA. A late data_ok after reset is not forwarded.
        add(1, 0, 32'h0,         1, 32'h8000_3000, 1, 0, 32'h0,         DATA, 1, 0, 0, 32'h0, 1, 0, 32'h0, 0);
        add(0, 0, 32'h0,         0, 32'h8000_3000, 0, 0, 32'h0,         NONE, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        add(1, 0, 32'h0,         0, 32'h8000_3000, 0, 1, 32'h0000_0055, NONE, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        add(1, 0, 32'h0,         0, 32'h8000_3000, 0, 0, 32'h0,         NONE, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        // Four single-cycle transactions with both requests held. After reset
        // last_owner is DATA, so round robin alternates INST, DATA, ...
        for (int k = 0; k < 4; k++) begin
            o = RR ? ((k % 2 == 0) ? INST : DATA) : DATA;
            add(1, 1, 32'h1FC0_0200 + 32'(4*k), 1, 32'h8000_4000 + 32'(4*k), 1, 1,
                32'hC0DE_0000 + 32'(k), o, 1,
                o == INST, o == INST, (o == INST) ? 32'hC0DE_0000 + 32'(k) : 32'h0,
                o == DATA, o == DATA, (o == DATA) ? 32'hC0DE_0000 + 32'(k) : 32'h0, 0);
        end
        // Single-cycle data transaction from IDLE. The state stays IDLE.
        add(1, 0, 32'h0,         1, 32'h8000_5000, 1, 1, 32'hDEAD_BEEF, DATA, 1, 0, 0, 32'h0, 1, 1, 32'hDEAD_BEEF, 0);
        add(1, 0, 32'h0,         0, 32'h8000_5000, 0, 0, 32'h0,         NONE, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);

        for (int i = 0; i < nvec; i++) begin
            @(negedge clk);
            rst       = vecs[i].rst;
            inst_req  = vecs[i].ir;
            inst_addr = vecs[i].ia;
            data_req  = vecs[i].dr;
            data_addr = vecs[i].da;
            m_addr_ok = vecs[i].aok;
            m_data_ok = vecs[i].dok;
            m_rdata   = vecs[i].rd;
            #4;
            chk(i, "m_req",        {31'd0, m_req},        {31'd0, vecs[i].mreq});
            chk(i, "m_addr",       m_addr,
                (vecs[i].own == INST) ? vecs[i].ia : (vecs[i].own == DATA) ? vecs[i].da : 32'h0);
            chk(i, "m_wdata",      m_wdata,
                (vecs[i].own == INST) ? 32'h1111_1111 : (vecs[i].own == DATA) ? 32'h2222_2222 : 32'h0);
            chk(i, "m_attr",       {27'd0, m_wr, m_size, m_uncached},
                (vecs[i].own == INST) ? 32'h5 : (vecs[i].own == DATA) ? 32'hA : 32'h0);
            chk(i, "inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, vecs[i].iaok});
            chk(i, "inst_data_ok", {31'd0, inst_data_ok}, {31'd0, vecs[i].idok});
            chk(i, "inst_rdata",   inst_rdata,            vecs[i].ird);
            chk(i, "data_addr_ok", {31'd0, data_addr_ok}, {31'd0, vecs[i].daok});
            chk(i, "data_data_ok", {31'd0, data_data_ok}, {31'd0, vecs[i].ddok});
            chk(i, "data_rdata",   data_rdata,            vecs[i].drd);
            chk(i, "busy",         {31'd0, busy},         {31'd0, vecs[i].busy});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
